// File: rtl/cpu_exec_rw_unit.sv
// CPU execution/transfer unit: ALU, internal word-bus mux and the
// motherboard read/write handshake controller.
module cpu_exec_rw_unit #(
   parameter int WORD_WIDTH = 32,
   parameter int FLAG_WIDTH = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   // ALU
   input  logic                  i_alu_oe,
   input  logic [3:0]            i_alu_opcode,
   input  logic [WORD_WIDTH-1:0] i_alu_a,
   input  logic [WORD_WIDTH-1:0] i_alu_b,
   input  logic                  i_alu_carry,
   output logic [WORD_WIDTH-1:0] o_alu_out,
   output logic [FLAG_WIDTH-1:0] o_alu_flags,
   // internal bus
   input  logic [2:0]            i_bus_sel,
   input  logic [WORD_WIDTH-1:0] i_t1_out,
   input  logic [WORD_WIDTH-1:0] i_t2_out,
   input  logic [WORD_WIDTH-1:0] i_dbg_in,
   output logic [WORD_WIDTH-1:0] o_bus_out,
   // read/write request side
   input  logic                  i_rw_req,
   input  logic                  i_rw_dir,
   input  logic [WORD_WIDTH-1:0] i_rw_addr,
   input  logic [WORD_WIDTH-1:0] i_rw_wdata,
   output logic                  o_rw_busy,
   output logic                  o_rw_done,
   output logic [WORD_WIDTH-1:0] o_rd_data,
   // motherboard side
   output logic [WORD_WIDTH-1:0] o_mobo_ctrl,
   input  logic [WORD_WIDTH-1:0] i_mobo_stat,
   output logic [WORD_WIDTH-1:0] o_mobo_addr,
   output logic [WORD_WIDTH-1:0] o_mobo_wdata,
   input  logic [WORD_WIDTH-1:0] i_mobo_rdata
);

   localparam int MSB = WORD_WIDTH - 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_ADC = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_SBB = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SHR = 4'd9;
   localparam logic [3:0] OP_SAR = 4'd10;
   localparam logic [3:0] OP_PSA = 4'd11;
   localparam logic [3:0] OP_PSB = 4'd12;
   localparam logic [3:0] OP_INC = 4'd13;
   localparam logic [3:0] OP_DEC = 4'd14;
   localparam logic [3:0] OP_CMP = 4'd15;

   localparam logic [WORD_WIDTH-1:0] CMD_NONE  = WORD_WIDTH'(0);
   localparam logic [WORD_WIDTH-1:0] CMD_READ  = WORD_WIDTH'(1);
   localparam logic [WORD_WIDTH-1:0] CMD_WRITE = WORD_WIDTH'(2);
   localparam logic [WORD_WIDTH-1:0] STAT_IDLE = WORD_WIDTH'(0);
   localparam logic [WORD_WIDTH-1:0] STAT_DONE = WORD_WIDTH'(2);

   // ------------------------------------------------------------------
   // ALU
   // ------------------------------------------------------------------
   logic [WORD_WIDTH:0]   w_a_ext;
   logic [WORD_WIDTH:0]   w_b_ext;
   logic [WORD_WIDTH:0]   w_cin_ext;
   logic [WORD_WIDTH:0]   w_one_ext;
   logic [WORD_WIDTH:0]   w_ext;
   logic [WORD_WIDTH-1:0] w_fres;
   logic [WORD_WIDTH-1:0] w_res;
   logic                  w_c;
   logic                  w_v;

   assign w_a_ext   = {1'b0, i_alu_a};
   assign w_b_ext   = {1'b0, i_alu_b};
   assign w_cin_ext = {{WORD_WIDTH{1'b0}}, i_alu_carry};
   assign w_one_ext = {{WORD_WIDTH{1'b0}}, 1'b1};

   // w_fres is the value the flags describe; for CMP it is the difference
   // while the visible result stays operand a.
   always_comb begin
      w_ext  = '0;
      w_fres = '0;
      w_c    = 1'b0;
      w_v    = 1'b0;
      case (i_alu_opcode)
         OP_ADD, OP_ADC: begin
            w_ext  = w_a_ext + w_b_ext +
                     ((i_alu_opcode == OP_ADC) ? w_cin_ext : '0);
            w_fres = w_ext[MSB:0];
            w_c    = w_ext[WORD_WIDTH];
            w_v    = (i_alu_a[MSB] == i_alu_b[MSB]) &&
                     (w_fres[MSB] != i_alu_a[MSB]);
         end
         OP_SUB, OP_SBB, OP_CMP: begin
            w_ext  = w_a_ext - w_b_ext -
                     ((i_alu_opcode == OP_SBB) ? w_cin_ext : '0);
            w_fres = w_ext[MSB:0];
            w_c    = w_ext[WORD_WIDTH];
            w_v    = (i_alu_a[MSB] != i_alu_b[MSB]) &&
                     (w_fres[MSB] != i_alu_a[MSB]);
         end
         OP_AND: w_fres = i_alu_a & i_alu_b;
         OP_OR:  w_fres = i_alu_a | i_alu_b;
         OP_XOR: w_fres = i_alu_a ^ i_alu_b;
         OP_NOT: w_fres = ~i_alu_a;
         OP_SHL: begin
            w_fres = {i_alu_a[MSB-1:0], 1'b0};
            w_c    = i_alu_a[MSB];
         end
         OP_SHR: begin
            w_fres = {1'b0, i_alu_a[MSB:1]};
            w_c    = i_alu_a[0];
         end
         OP_SAR: begin
            w_fres = {i_alu_a[MSB], i_alu_a[MSB:1]};
            w_c    = i_alu_a[0];
         end
         OP_PSA: w_fres = i_alu_a;
         OP_PSB: w_fres = i_alu_b;
         OP_INC: begin
            w_ext  = w_a_ext + w_one_ext;
            w_fres = w_ext[MSB:0];
            w_c    = w_ext[WORD_WIDTH];
            w_v    = !i_alu_a[MSB] && w_fres[MSB];
         end
         OP_DEC: begin
            w_ext  = w_a_ext - w_one_ext;
            w_fres = w_ext[MSB:0];
            w_c    = w_ext[WORD_WIDTH];
            w_v    = i_alu_a[MSB] && !w_fres[MSB];
         end
         default: w_fres = '0;
      endcase
   end

   assign w_res       = (i_alu_opcode == OP_CMP) ? i_alu_a : w_fres;
   assign o_alu_out   = i_alu_oe ? w_res : '0;
   assign o_alu_flags = {~^w_fres[7:0], w_v, w_fres[MSB], (w_fres == '0), w_c};

   // ------------------------------------------------------------------
   // Internal word bus
   // ------------------------------------------------------------------
   logic [WORD_WIDTH-1:0] r_rd_data;
   logic [WORD_WIDTH-1:0] r_mobo_addr;

   always_comb begin
      o_bus_out = '0;
      case (i_bus_sel)
         3'd1:    o_bus_out = i_t1_out;
         3'd2:    o_bus_out = i_t2_out;
         3'd3:    o_bus_out = o_alu_out;
         3'd4:    o_bus_out = r_rd_data;
         3'd5:    o_bus_out = r_mobo_addr;
         3'd6:    o_bus_out = i_dbg_in;
         default: o_bus_out = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Read/write handshake FSM
   //   state      | meaning
   //   ST_IDLE    | no transaction; accepts i_rw_req, latches addr/data/dir
   //   ST_WAIT    | waiting for motherboard IDLE before issuing command
   //   ST_ACTIVE  | command driven; waiting for motherboard DONE
   //   ST_RELEASE | command dropped; waiting for motherboard IDLE, then done
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACTIVE,
      ST_RELEASE
   } rw_state_t;

   rw_state_t             r_state;
   logic                  r_dir;
   logic                  r_busy;
   logic                  r_done;
   logic [WORD_WIDTH-1:0] r_mobo_ctrl;
   logic [WORD_WIDTH-1:0] r_mobo_wdata;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_dir        <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_mobo_ctrl  <= CMD_NONE;
         r_mobo_addr  <= '0;
         r_mobo_wdata <= '0;
         r_rd_data    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_rw_req) begin
                  r_dir        <= i_rw_dir;
                  r_mobo_addr  <= i_rw_addr;
                  r_mobo_wdata <= i_rw_wdata;
                  r_busy       <= 1'b1;
                  r_state      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_mobo_stat == STAT_IDLE) begin
                  r_mobo_ctrl <= r_dir ? CMD_WRITE : CMD_READ;
                  r_state     <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (i_mobo_stat == STAT_DONE) begin
                  r_mobo_ctrl <= CMD_NONE;
                  if (!r_dir) begin
                     r_rd_data <= i_mobo_rdata;
                  end
                  r_state <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (i_mobo_stat == STAT_IDLE) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_mobo_ctrl <= CMD_NONE;
               r_busy      <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_rw_busy    = r_busy;
   assign o_rw_done    = r_done;
   assign o_rd_data    = r_rd_data;
   assign o_mobo_ctrl  = r_mobo_ctrl;
   assign o_mobo_addr  = r_mobo_addr;
   assign o_mobo_wdata = r_mobo_wdata;

endmodule

// File: tb/tb_cpu_exec_rw_unit.sv
// Bench for cpu_exec_rw_unit: ALU/bus vectors against an arithmetic model,
// transactions against a motherboard responder with a scoreboard monitor.
module tb_cpu_exec_rw_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          alu_oe = 1'b1;
   logic [3:0]    alu_opcode = '0;
   logic [W-1:0]  alu_a = '0, alu_b = '0;
   logic          alu_carry = 1'b0;
   logic [W-1:0]  alu_out;
   logic [4:0]    alu_flags;
   logic [2:0]    bus_sel = '0;
   logic [W-1:0]  t1_out = '0, t2_out = '0, dbg_in = '0;
   logic [W-1:0]  bus_out;
   logic          rw_req = 1'b0, rw_dir = 1'b0;
   logic [W-1:0]  rw_addr = '0, rw_wdata = '0;
   logic          rw_busy, rw_done;
   logic [W-1:0]  rd_data, mobo_ctrl, mobo_addr, mobo_wdata;
   logic [W-1:0]  mobo_stat = '0, mobo_rdata = '0;

   always #5 clk = ~clk;

   cpu_exec_rw_unit #(.WORD_WIDTH(W), .FLAG_WIDTH(5)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_alu_oe(alu_oe), .i_alu_opcode(alu_opcode), .i_alu_a(alu_a), .i_alu_b(alu_b),
      .i_alu_carry(alu_carry), .o_alu_out(alu_out), .o_alu_flags(alu_flags),
      .i_bus_sel(bus_sel), .i_t1_out(t1_out), .i_t2_out(t2_out), .i_dbg_in(dbg_in),
      .o_bus_out(bus_out),
      .i_rw_req(rw_req), .i_rw_dir(rw_dir), .i_rw_addr(rw_addr), .i_rw_wdata(rw_wdata),
      .o_rw_busy(rw_busy), .o_rw_done(rw_done), .o_rd_data(rd_data),
      .o_mobo_ctrl(mobo_ctrl), .i_mobo_stat(mobo_stat), .o_mobo_addr(mobo_addr),
      .o_mobo_wdata(mobo_wdata), .i_mobo_rdata(mobo_rdata)
   );

   int n_pass = 0;
   int n_total = 0;
   int n_done = 0;

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %h, expected %h", name, got, exp);
      else n_pass++;
   endtask

   task automatic fail_evt(input string name);
      n_total++;
      $display("FAIL %s: event not as expected", name);
   endtask

   // ---------------- ALU reference: plain integer arithmetic ----------------
   function automatic void alu_ref(input logic [3:0] op, input logic [W-1:0] a, b,
                                   input logic cin, output logic [W-1:0] r,
                                   output logic [4:0] f);
      longint ua, ub, sa, sb, u, s;
      logic [W-1:0] fr;
      logic c, v, arith;
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      u = 0; s = 0; c = 1'b0; arith = 1'b0; r = '0;
      case (op)
         4'd0:  begin u = ua + ub;             s = sa + sb;             c = (u >= 64'sd4294967296); arith = 1; end
         4'd1:  begin u = ua + ub + cin;       s = sa + sb + cin;       c = (u >= 64'sd4294967296); arith = 1; end
         4'd2,
         4'd15: begin u = ua - ub;             s = sa - sb;             c = (u < 0); arith = 1; end
         4'd3:  begin u = ua - ub - cin;       s = sa - sb - cin;       c = (u < 0); arith = 1; end
         4'd4:  r = a & b;
         4'd5:  r = a | b;
         4'd6:  r = a ^ b;
         4'd7:  r = ~a;
         4'd8:  begin r = a << 1;              c = a[W-1]; end
         4'd9:  begin r = a >> 1;              c = a[0];   end
         4'd10: begin r = W'($signed(a) >>> 1); c = a[0];  end
         4'd11: r = a;
         4'd12: r = b;
         4'd13: begin u = ua + 1; s = sa + 1; c = (u >= 64'sd4294967296); arith = 1; end
         default: begin u = ua - 1; s = sa - 1; c = (u < 0); arith = 1; end
      endcase
      if (arith) r = u[W-1:0];
      v = arith && (s > 64'sd2147483647 || s < -64'sd2147483648);
      fr = r;
      if (op == 4'd15) r = a;
      f = {($countones(fr[7:0]) % 2) == 0, v, fr[W-1], fr == '0, c};
   endfunction

   task automatic alu_apply(input logic [3:0] op, input logic [W-1:0] a, b, input logic cin,
                            input logic oe);
      alu_opcode = op; alu_a = a; alu_b = b; alu_carry = cin; alu_oe = oe;
      #1;
   endtask

   // ---------------- motherboard responder ----------------
   int           mb_busy_cycles = 2;
   bit           force_busy = 0;
   logic [W-1:0] force_val = 32'd1;
   logic [W-1:0] mb_mem [logic [W-1:0]];

   function automatic logic [W-1:0] blank_word(input logic [W-1:0] addr);
      return addr ^ 32'hA5A5_0000;
   endfunction

   initial begin
      int phase, cnt;
      logic [W-1:0] rv;
      phase = 0; cnt = 0; rv = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin phase = 0; mobo_stat = 0; continue; end
         if (force_busy) begin mobo_stat = force_val; continue; end
         case (phase)
            0: begin
               mobo_rdata = $urandom();
               if (mobo_ctrl != 0) begin
                  if (mobo_ctrl == 2) mb_mem[mobo_addr] = mobo_wdata;
                  rv = mb_mem.exists(mobo_addr) ? mb_mem[mobo_addr] : blank_word(mobo_addr);
                  cnt = mb_busy_cycles;
                  if (cnt == 0) begin phase = 2; mobo_stat = 2; mobo_rdata = rv; end
                  else begin phase = 1; mobo_stat = 1; end
               end else mobo_stat = 0;
            end
            1: begin
               mobo_rdata = $urandom();
               cnt--;
               if (cnt == 0) begin phase = 2; mobo_stat = 2; mobo_rdata = rv; end
            end
            default: if (mobo_ctrl == 0) begin phase = 0; mobo_stat = 0; end
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      bit           dir;
      logic [W-1:0] addr;
      logic [W-1:0] wdata;
      logic [W-1:0] rd;
   } exp_t;
   exp_t q[$];

   logic [W-1:0] ref_mem [logic [W-1:0]];
   logic [W-1:0] last_rd = '0;
   logic [W-1:0] last_addr = '0;

   initial begin
      logic [W-1:0] pc;
      bit pd;
      exp_t e;
      pc = '0; pd = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin pc = '0; pd = 0; continue; end
         if (mobo_ctrl != 0 && pc == 0) begin
            if (q.size() == 0) fail_evt("unexpected_cmd");
            else begin
               e = q[0];
               chk("cmd_code", mobo_ctrl, e.dir ? 32'd2 : 32'd1);
               chk("cmd_addr", mobo_addr, e.addr);
               if (e.dir) chk("cmd_wdata", mobo_wdata, e.wdata);
            end
         end
         if (rw_done) begin
            if (pd) fail_evt("done_double_pulse");
            else if (q.size() == 0) fail_evt("unexpected_done");
            else begin
               e = q.pop_front();
               chk("done_rd_data", rd_data, e.rd);
               chk("done_addr", mobo_addr, e.addr);
               chk("done_ctrl_none", mobo_ctrl, 0);
               chk("done_busy", {31'd0, rw_busy}, 0);
               n_done++;
            end
         end
         pc = mobo_ctrl;
         pd = rw_done;
      end
   end

   task automatic issue(input bit dir, input logic [W-1:0] addr, input logic [W-1:0] wdata);
      exp_t e;
      bit ok;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         if (!rw_busy) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) fail_evt("wait_idle_timeout");
      @(negedge clk);
      rw_req = 1'b1; rw_dir = dir; rw_addr = addr; rw_wdata = wdata;
      e.dir = dir; e.addr = addr; e.wdata = wdata;
      if (dir) begin
         ref_mem[addr] = wdata;
         e.rd = last_rd;
      end else begin
         e.rd = ref_mem.exists(addr) ? ref_mem[addr] : blank_word(addr);
         last_rd = e.rd;
      end
      last_addr = addr;
      q.push_back(e);
      @(negedge clk);
      rw_req = 1'b0;
   endtask

   task automatic wait_done(input int start);
      bit ok;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         if (n_done > start) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) fail_evt("done_timeout");
   endtask

   task automatic wait_cmd();
      bit ok;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         if (mobo_ctrl != 0) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) fail_evt("cmd_timeout");
   endtask

   // ---------------- main stimulus ----------------
   initial begin
      logic [W-1:0] r, exp_bus;
      logic [4:0] f;
      int d0;

      #1;
      chk("rst_ctrl", mobo_ctrl, 0);
      chk("rst_busy", {31'd0, rw_busy}, 0);
      chk("rst_done", {31'd0, rw_done}, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_addr", mobo_addr, 0);
      chk("rst_wdata", mobo_wdata, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // ALU directed
      alu_apply(4'd0, 32'd3, 32'd5, 1'b0, 1'b1);
      chk("add_3_5", alu_out, 32'd8);
      chk("add_3_5_flags", {27'd0, alu_flags}, 32'b00000);
      alu_apply(4'd2, 32'd3, 32'd5, 1'b0, 1'b1);
      chk("sub_3_5", alu_out, 32'hFFFF_FFFE);
      chk("sub_3_5_flags", {27'd0, alu_flags}, 32'b00101);
      alu_apply(4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
      chk("add_wrap", alu_out, 32'd0);
      chk("add_wrap_flags", {27'd0, alu_flags}, 32'b10011);
      alu_apply(4'd13, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1);
      chk("inc_ovf_out", alu_out, 32'h8000_0000);
      chk("inc_ovf_flag", {31'd0, alu_flags[3]}, 1);
      alu_apply(4'd0, 32'd3, 32'd5, 1'b0, 1'b0);
      chk("alu_oe0_out", alu_out, 0);
      chk("alu_oe0_flags", {27'd0, alu_flags}, 32'b00000);

      // ALU random
      for (int i = 0; i < 200; i++) begin
         logic [3:0] op;
         logic [W-1:0] a, b;
         logic cin, oe;
         op = 4'($urandom_range(0, 15));
         a = (i % 8 == 0) ? 32'h8000_0000 : (i % 8 == 1) ? 32'h7FFF_FFFF : $urandom();
         b = (i % 5 == 0) ? a : $urandom();
         cin = 1'($urandom_range(0, 1));
         oe = ($urandom_range(0, 7) != 0);
         alu_apply(op, a, b, cin, oe);
         alu_ref(op, a, b, cin, r, f);
         chk($sformatf("alu_out_op%0d", op), alu_out, oe ? r : 32'd0);
         chk($sformatf("alu_flags_op%0d", op), {27'd0, alu_flags}, {27'd0, f});
      end

      // Write: addr 3, data 5, motherboard IDLE -> BUSY x2 -> DONE -> IDLE
      mb_busy_cycles = 2;
      d0 = n_done;
      issue(1'b1, 32'd3, 32'd5);
      chk("wr_busy_after_accept", {31'd0, rw_busy}, 1);
      chk("wr_ctrl_in_wait", mobo_ctrl, 0);
      @(negedge clk);
      chk("wr_ctrl_write", mobo_ctrl, 32'd2);
      chk("wr_mobo_addr", mobo_addr, 32'd3);
      chk("wr_mobo_wdata", mobo_wdata, 32'd5);
      wait_done(d0);
      repeat (5) @(negedge clk);
      chk("wr_single_done", n_done, d0 + 1);

      // Read back addr 3
      d0 = n_done;
      issue(1'b0, 32'd3, 32'd0);
      @(negedge clk);
      chk("rd_ctrl_read", mobo_ctrl, 32'd1);
      wait_done(d0);
      chk("rd_data_5", rd_data, 32'd5);
      bus_sel = 3'd4; #1;
      chk("bus_rd_data", bus_out, 32'd5);

      // Bus: every select
      t1_out = 32'h1111_1111; t2_out = 32'h2222_2222; dbg_in = 32'hDDDD_0007;
      alu_apply(4'd0, 32'd3, 32'd5, 1'b0, 1'b1);
      for (int s = 0; s < 8; s++) begin
         bus_sel = 3'(s); #1;
         case (s)
            1: exp_bus = t1_out;
            2: exp_bus = t2_out;
            3: exp_bus = 32'd8;
            4: exp_bus = last_rd;
            5: exp_bus = last_addr;
            6: exp_bus = dbg_in;
            default: exp_bus = 32'd0;
         endcase
         chk($sformatf("bus_sel%0d", s), bus_out, exp_bus);
      end

      // Stall in WAIT with a non-IDLE status
      force_val = ($urandom_range(0, 1) != 0) ? 32'd1 : 32'd3;
      force_busy = 1;
      @(negedge clk);
      d0 = n_done;
      issue(1'b1, 32'd6, 32'h0000_CAFE);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_ctrl_none", mobo_ctrl, 0);
         chk("stall_busy", {31'd0, rw_busy}, 1);
      end
      force_busy = 0;
      wait_done(d0);

      // rw_req during ACTIVE must not relatch
      mb_busy_cycles = 6;
      d0 = n_done;
      issue(1'b1, 32'd2, 32'h1234_5678);
      wait_cmd();
      rw_req = 1'b1; rw_addr = 32'hBEEF; rw_wdata = 32'h0BAD_0BAD; rw_dir = 1'b0;
      repeat (2) @(negedge clk);
      rw_req = 1'b0;
      chk("ignore_addr", mobo_addr, 32'd2);
      chk("ignore_wdata", mobo_wdata, 32'h1234_5678);
      wait_done(d0);

      // Asynchronous reset during ACTIVE
      mb_busy_cycles = 5;
      issue(1'b0, 32'd3, 32'd0);
      wait_cmd();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_ctrl_none", mobo_ctrl, 0);
      chk("arst_busy", {31'd0, rw_busy}, 0);
      q.delete();
      last_rd = '0;
      last_addr = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("arst_rd_data", rd_data, 0);
      chk("arst_addr", mobo_addr, 0);
      @(negedge clk);
      chk("arst_idle_busy", {31'd0, rw_busy}, 0);
      mb_busy_cycles = 0;
      d0 = n_done;
      issue(1'b0, 32'd3, 32'd0);
      wait_done(d0);

      // Random transactions
      for (int i = 0; i < 25; i++) begin
         mb_busy_cycles = $urandom_range(0, 3);
         d0 = n_done;
         issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)), $urandom());
         wait_done(d0);
      end
      repeat (3) @(negedge clk);
      chk("queue_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
